coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

Coherence bus controller sitting directly downstream of the two per-core dcache control units and upstream of the unified RAM port. It arbitrates between core 0 and core 1 block transactions (two-word reads, two-word writebacks) and snoops the non-requesting cache on reads. It performs a cache-to-cache transfer with a simultaneous RAM update when the snooped cache holds a modified copy, and propagates invalidation requests (`ccwrite`) to the other cache.

## Interface
- No parameters. Word is 32 bits; a block is two words (`daddr[2]` selects the word). `i` is 0 or 1; the other cache is `j = 1-i`.
- `CLK`  in  1  system clock
- `nRST`  in  1  reset. One clock; reset is asynchronous and active-low.
- `dREN[1:0]`  in  2  per-cache word read request
- `dWEN[1:0]`  in  2  per-cache word write request
- `daddr0`, `daddr1`  in  32  per-cache word address
- `dstore0`, `dstore1`  in  32  per-cache write data
- `cctrans[1:0]`  in  2  cache has a bus transaction, or is answering a snoop
- `ccwrite[1:0]`  in  2  read-exclusive request, or snoop reply "modified"
- `dwait[1:0]`  out  2  low for one cycle when the current word completes
- `dload0`, `dload1`  out  32  read data, valid while `dwait[i]` is low
- `ccwait[1:0]`  out  2  cache is being snooped
- `ccinv[1:0]`  out  2  invalidate the snooped line
- `ccsnoopaddr0`, `ccsnoopaddr1`  out  32  snoop address
- `ramREN`, `ramWEN`  out  1  RAM request
- `ramaddr`  out  32  RAM address
- `ramstore`  out  32  RAM write data
- `ramload`  in  32  RAM read data
- `ram_ready`  in  1  one-cycle pulse: current RAM access has completed (latency ≥1 cycle)

## Operation
- States:
  - IDLE
  - SNOOP
  - SNOOP_DEC
  - MEM_R0, MEM_R1
  - C2C_W0, C2C_W1
  - WB_W0, WB_W1
- Registers:
  - `req` (1 bit): current requester
  - `last_grant` (1 bit): reset value 1, so core 0 wins first
- IDLE:
  - Candidates are caches with `cctrans[i]` high and `dREN[i]|dWEN[i]` high.
  - If both are candidates, grant `~last_grant`; otherwise grant the sole candidate.
  - On grant, latch `req` and update `last_grant`.
  - If `dWEN[req]` → WB_W0; else → SNOOP.
- SNOOP (exactly 1 cycle):
  - Drive `ccwait[j]=1`, `ccsnoopaddr_j=daddr_req`, `ccinv[j]=ccwrite[req]`.
  - → SNOOP_DEC.
- SNOOP_DEC (1 cycle, same snoop outputs):
  - If `cctrans[j] & ccwrite[j]` → C2C_W0; else → MEM_R0.
- MEM_R0 / MEM_R1:
  - `ramREN=1`, `ramaddr=daddr_req`, `dload_req=ramload`, `dwait[req]=~ram_ready`.
  - On `ram_ready`: MEM_R0 → MEM_R1, MEM_R1 → IDLE.
  - `ccwait[j]`/`ccinv[j]` stay asserted through the end of the transaction.
- C2C_W0 / C2C_W1 (snooped cache flushes its block while requester receives it):
  - `ramWEN=1`, `ramaddr=daddr_j`, `ramstore=dstore_j`, `dload_req=dstore_j`.
  - `dwait[req]=dwait[j]=~ram_ready`.
  - On `ram_ready`: C2C_W0 → C2C_W1, C2C_W1 → IDLE.
- WB_W0 / WB_W1:
  - `ramWEN=1`, `ramaddr=daddr_req`, `ramstore=dstore_req`, `dwait[req]=~ram_ready`.
  - On `ram_ready`: WB_W0 → WB_W1, WB_W1 → IDLE.
  - No snoop is performed.
- A dcache that does writeback-then-load releases the bus after WB_W1 and re-arbitrates; the other core may take the bus in between.
- Outside IDLE, `cctrans` of the requester is not re-sampled; the transaction runs to completion.
- Outputs not named in a state hold their defaults:
  - `dwait=2'b11`
  - `dload*=0`
  - `ccwait=ccinv=0`
  - `ccsnoopaddr*=0`
  - RAM controls 0, `ramaddr=ramstore=0`

## Timing
- Reset (asynchronous, immediate): state IDLE, `last_grant=1`, `req=0`, all outputs at defaults (`dwait=2'b11`, everything else 0).
- A reset asserted mid-transaction aborts it with no further RAM activity.
- Grant latency: request visible in cycle t → SNOOP or WB_W0 in t+1.
- Minimum read latency with 1-cycle RAM: IDLE → SNOOP → SNOOP_DEC → MEM_R0, so the first `dwait` low occurs 3 cycles after grant and the second 1 cycle later.
- `dwait[req]` low in exactly the `ram_ready` cycle; never low in IDLE, SNOOP or SNOOP_DEC.
- Back-to-back transactions: after returning to IDLE, the next grant takes effect the following cycle. No bubble beyond the IDLE cycle.
- A simultaneous new request from the current requester and the other core in IDLE: the other core wins (round-robin).
- `ram_ready` arriving in a non-RAM state is ignored.

## Test plan
- Reset with both `cctrans` high → `dwait=2'b11`, all RAM/snoop outputs 0. After release, core 0 is granted first.
- Core 0 read, `daddr0` 0x100 then 0x104, core 1 snoop reply clean, RAM returns 0xAAAA0000 / 0xAAAA0004 → `ccsnoopaddr1=0x100`, `ccwait[1]=1`, `dload0` values as given, `dwait[0]` low twice, `ccinv[1]=0`.
- Core 1 read-exclusive (`ccwrite[1]=1`) at 0x200, core 0 replies modified with `dstore0` 0x11 / 0x22 → `ccinv[0]=1`, `ramWEN` writes 0x11@0x200 and 0x22@0x204, `dload1=0x11` then `0x22`, both `dwait` bits drop together.
- Core 0 writeback 0xDEAD@0x300, 0xBEEF@0x304 → two RAM writes, no `ccwait` asserted at any point.
- Both cores request continuously → grants alternate 0,1,0,1 over four transactions.
- Reset pulsed during MEM_R1 → outputs return to defaults immediately; the next grant after release goes to core 0.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// Coherence bus controller: arbitrates two dcaches onto one RAM port, snoops the
// non-requesting cache on reads and forwards modified blocks cache-to-cache.
module coherence_bus_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [31:0] daddr0,
    input  logic [31:0] daddr1,
    input  logic [31:0] dstore0,
    input  logic [31:0] dstore1,
    input  logic [1:0]  cctrans,
    input  logic [1:0]  ccwrite,
    output logic [1:0]  dwait,
    output logic [31:0] dload0,
    output logic [31:0] dload1,
    output logic [1:0]  ccwait,
    output logic [1:0]  ccinv,
    output logic [31:0] ccsnoopaddr0,
    output logic [31:0] ccsnoopaddr1,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_SNOOP_DEC,
        ST_MEM_R0,
        ST_MEM_R1,
        ST_C2C_W0,
        ST_C2C_W1,
        ST_WB_W0,
        ST_WB_W1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_req;
    logic             r_last_grant;

    logic [1:0]       w_cand;
    logic             w_gnt;
    logic             w_oth;
    logic [31:0]      w_daddr_req;
    logic [31:0]      w_daddr_oth;
    logic [31:0]      w_dstore_req;
    logic [31:0]      w_dstore_oth;
    logic             w_snoop_hit;
    logic [1:0][31:0] w_dload;
    logic [1:0][31:0] w_snpaddr;

    assign w_cand = cctrans & (dREN | dWEN);
    // Round-robin only matters on a tie; a lone candidate always wins.
    assign w_gnt  = (&w_cand) ? ~r_last_grant : w_cand[1];
    assign w_oth  = ~r_req;

    assign w_daddr_req  = r_req ? daddr1  : daddr0;
    assign w_daddr_oth  = r_req ? daddr0  : daddr1;
    assign w_dstore_req = r_req ? dstore1 : dstore0;
    assign w_dstore_oth = r_req ? dstore0 : dstore1;
    assign w_snoop_hit  = cctrans[w_oth] & ccwrite[w_oth];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_req        <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (r_state == ST_IDLE && |w_cand) begin
            r_req        <= w_gnt;
            r_last_grant <= w_gnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (|w_cand) w_next_state = dWEN[w_gnt] ? ST_WB_W0 : ST_SNOOP;
            ST_SNOOP:     w_next_state = ST_SNOOP_DEC;
            ST_SNOOP_DEC: w_next_state = w_snoop_hit ? ST_C2C_W0 : ST_MEM_R0;
            ST_MEM_R0:    if (ram_ready) w_next_state = ST_MEM_R1;
            ST_MEM_R1:    if (ram_ready) w_next_state = ST_IDLE;
            ST_C2C_W0:    if (ram_ready) w_next_state = ST_C2C_W1;
            ST_C2C_W1:    if (ram_ready) w_next_state = ST_IDLE;
            ST_WB_W0:     if (ram_ready) w_next_state = ST_WB_W1;
            ST_WB_W1:     if (ram_ready) w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // The snooped cache stays in snoop mode until the requester's block is done.
    always_comb begin
        dwait     = 2'b11;
        w_dload   = '0;
        ccwait    = '0;
        ccinv     = '0;
        w_snpaddr = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        case (r_state)
            ST_SNOOP, ST_SNOOP_DEC: begin
                ccwait[w_oth]    = 1'b1;
                ccinv[w_oth]     = ccwrite[r_req];
                w_snpaddr[w_oth] = w_daddr_req;
            end
            ST_MEM_R0, ST_MEM_R1: begin
                ccwait[w_oth]  = 1'b1;
                ccinv[w_oth]   = ccwrite[r_req];
                ramREN         = 1'b1;
                ramaddr        = w_daddr_req;
                w_dload[r_req] = ramload;
                dwait[r_req]   = ~ram_ready;
            end
            ST_C2C_W0, ST_C2C_W1: begin
                ccwait[w_oth]  = 1'b1;
                ccinv[w_oth]   = ccwrite[r_req];
                ramWEN         = 1'b1;
                ramaddr        = w_daddr_oth;
                ramstore       = w_dstore_oth;
                w_dload[r_req] = w_dstore_oth;
                dwait          = {2{~ram_ready}};
            end
            ST_WB_W0, ST_WB_W1: begin
                ramWEN       = 1'b1;
                ramaddr      = w_daddr_req;
                ramstore     = w_dstore_req;
                dwait[r_req] = ~ram_ready;
            end
            default: ;
        endcase
    end

    assign dload0       = w_dload[0];
    assign dload1       = w_dload[1];
    assign ccsnoopaddr0 = w_snpaddr[0];
    assign ccsnoopaddr1 = w_snpaddr[1];

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: drives both dcaches and a RAM model,
// predicts grants, snoops, RAM accesses and load data at transaction level.
module tb_coherence_bus_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  dREN = '0;
    logic [1:0]  dWEN = '0;
    logic [1:0]  cctrans = '0;
    logic [1:0]  ccwrite = '0;
    logic [31:0] da [2];
    logic [31:0] ds [2];
    logic [1:0]  dwait, ccwait, ccinv;
    logic [31:0] dload0, dload1, ccsnoopaddr0, ccsnoopaddr1, ramaddr, ramstore;
    logic        ramREN, ramWEN;
    logic [31:0] ramload = '0;
    logic        ram_ready = 1'b0;

    coherence_bus_ctrl dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN),
        .daddr0(da[0]), .daddr1(da[1]), .dstore0(ds[0]), .dstore1(ds[1]),
        .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait),
        .dload0(dload0), .dload1(dload1), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr0(ccsnoopaddr0), .ccsnoopaddr1(ccsnoopaddr1),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [1:0] dw; logic [31:0] l0; logic [31:0] l1; } ev_t;
    typedef struct { logic we; logic [31:0] a; logic [31:0] d; } ram_t;
    typedef struct { int j; logic [31:0] a; logic inv; } snp_t;

    ev_t  ev_q[$];
    ram_t ram_q[$];
    snp_t snp_q[$];

    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] exp_mem [logic [31:0]];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   fixed = 1'b1;
    int   m_last = 1;
    logic [1:0] prev_ccw = '0;

    bit          p_we [2];
    bit          p_excl [2];
    logic [31:0] p_a [2];
    logic [31:0] p_d [2][2];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // RAM device: random 0..2 extra wait cycles, checks each access against the scoreboard.
    initial begin
        int   cnt;
        int   lat;
        ram_t r;
        cnt = 0;
        lat = 0;
        forever begin
            @(posedge CLK);
            #3;
            if (!nRST) begin
                ram_ready = 1'b0;
                cnt = 0;
            end else begin
                ram_ready = 1'b0;
                if (ramREN || ramWEN) begin
                    if (cnt >= (fixed ? 0 : lat)) begin
                        ram_ready = 1'b1;
                        cnt = 0;
                        lat = $urandom_range(0, 2);
                        if (ram_q.size() == 0) begin
                            chk("unexpected ram access", 32'({ramREN, ramWEN}), 32'h0);
                        end else begin
                            r = ram_q.pop_front();
                            chk("ramWEN", 32'(ramWEN), 32'(r.we));
                            chk("ramREN", 32'(ramREN), 32'(!r.we));
                            chk("ramaddr", ramaddr, r.a);
                            if (r.we) chk("ramstore", ramstore, r.d);
                        end
                        if (ramWEN) ram_mem[ramaddr] = ramstore;
                        else        ramload = ram_rd(ramaddr);
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: word completions and snoop starts are popped and compared in order.
    initial begin
        ev_t  e;
        snp_t s;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                prev_ccw = '0;
            end else begin
                if (dwait != 2'b11) begin
                    if (ev_q.size() == 0) begin
                        chk("unexpected dwait", 32'(dwait), 32'h3);
                    end else begin
                        e = ev_q.pop_front();
                        chk("dwait", 32'(dwait), 32'(e.dw));
                        chk("dload0", dload0, e.l0);
                        chk("dload1", dload1, e.l1);
                    end
                end
                if (ccwait != 2'b00 && prev_ccw == 2'b00) begin
                    if (snp_q.size() == 0) begin
                        chk("unexpected ccwait", 32'(ccwait), 32'h0);
                    end else begin
                        s = snp_q.pop_front();
                        chk("ccwait", 32'(ccwait), 32'(1) << s.j);
                        chk("ccinv", 32'(ccinv), s.inv ? (32'(1) << s.j) : 32'h0);
                        chk("ccsnoopaddr", s.j == 1 ? ccsnoopaddr1 : ccsnoopaddr0, s.a);
                        chk("ccsnoopaddr idle side", s.j == 1 ? ccsnoopaddr0 : ccsnoopaddr1, 32'h0);
                    end
                end
                prev_ccw = ccwait;
            end
        end
    end

    task automatic present(input int i);
        cctrans[i] = 1'b1;
        dREN[i]    = !p_we[i];
        dWEN[i]    = p_we[i];
        ccwrite[i] = p_excl[i];
        da[i]      = p_a[i];
        ds[i]      = p_d[i][0];
    endtask

    // Predict and run one granted block transaction for core w; mod means the
    // other cache answers the snoop with a modified block (m0, m1).
    task automatic serve(input int w, input bit mod, input logic [31:0] m0, input logic [31:0] m1);
        int          j, k, n, t0, tg;
        bit          got;
        logic [1:0]  dw;
        logic [31:0] v;
        logic [31:0] md [2];
        ev_t         e;
        ram_t        r;
        snp_t        s;
        j = 1 - w;
        md[0] = m0;
        md[1] = m1;
        m_last = w;
        t0 = cyc;
        if (!p_we[w]) begin
            s.j = j; s.a = p_a[w]; s.inv = p_excl[w];
            snp_q.push_back(s);
        end
        for (int q = 0; q < 2; q++) begin
            r.a = p_a[w] + 32'(4 * q);
            dw = 2'b11;
            dw[w] = 1'b0;
            if (p_we[w]) begin
                r.we = 1'b1; r.d = p_d[w][q]; exp_mem[r.a] = r.d; v = '0;
            end else if (mod) begin
                r.we = 1'b1; r.d = md[q]; exp_mem[r.a] = r.d; v = md[q]; dw = 2'b00;
            end else begin
                r.we = 1'b0; r.d = '0; v = exp_rd(r.a);
            end
            ram_q.push_back(r);
            e.dw = dw;
            e.l0 = (w == 0) ? v : 32'h0;
            e.l1 = (w == 1) ? v : 32'h0;
            ev_q.push_back(e);
        end
        if (mod) begin
            cctrans[j] = 1'b1; ccwrite[j] = 1'b1; da[j] = p_a[w]; ds[j] = m0;
        end
        k = 0;
        n = 0;
        while (k < 2 && n < 60) begin
            @(negedge CLK);
            got = !dwait[w];
            tg  = cyc;
            @(posedge CLK);
            #2;
            n++;
            if (got) begin
                if (k == 0 && fixed) chk("grant latency", 32'(tg - t0), p_we[w] ? 32'd1 : 32'd3);
                k++;
                if (k == 1) begin
                    da[w] = p_a[w] + 32'd4;
                    ds[w] = p_d[w][1];
                    if (mod) begin da[j] = p_a[w] + 32'd4; ds[j] = m1; end
                end
            end
        end
        if (k < 2) begin
            errors++;
            $display("FAIL transaction timeout: core %0d got %0d words expected 2", w, k);
        end
        cctrans[w] = 1'b0; dREN[w] = 1'b0; dWEN[w] = 1'b0; ccwrite[w] = 1'b0;
        if (mod) begin cctrans[j] = 1'b0; ccwrite[j] = 1'b0; end
    endtask

    task automatic round(input bit b0, input bit b1);
        int w;
        bit both;
        bit mod;
        bit b [2];
        b[0] = b0;
        b[1] = b1;
        both = b0 && b1;
        for (int i = 0; i < 2; i++) begin
            if (b[i]) begin
                p_we[i]   = ($urandom_range(0, 1) == 1);
                p_a[i]    = 32'h400 + 32'($urandom_range(0, 7)) * 32'd8;
                p_d[i][0] = $urandom;
                p_d[i][1] = $urandom;
                p_excl[i] = !p_we[i] && !both && ($urandom_range(0, 1) == 1);
                present(i);
            end
        end
        w = both ? 1 - m_last : (b0 ? 0 : 1);
        mod = !both && !p_we[w] && ($urandom_range(0, 1) == 1);
        serve(w, mod, $urandom, $urandom);
        if (both) begin
            w = 1 - w;
            mod = !p_we[w] && ($urandom_range(0, 1) == 1);
            serve(w, mod, $urandom, $urandom);
        end
    endtask

    initial begin
        int   n;
        int   mask;
        ev_t  e;
        ram_t r;
        snp_t s;
        da[0] = '0; da[1] = '0; ds[0] = '0; ds[1] = '0;
        ram_mem[32'h100] = 32'hAAAA0000; ram_mem[32'h104] = 32'hAAAA0004;
        exp_mem[32'h100] = 32'hAAAA0000; exp_mem[32'h104] = 32'hAAAA0004;
        cctrans = 2'b11;
        dREN    = 2'b11;
        repeat (3) @(posedge CLK);
        #2;
        chk("reset dwait", 32'(dwait), 32'h3);
        chk("reset ramREN", 32'(ramREN), 32'h0);
        chk("reset ramWEN", 32'(ramWEN), 32'h0);
        chk("reset ramaddr", ramaddr, 32'h0);
        chk("reset ramstore", ramstore, 32'h0);
        chk("reset ccwait", 32'(ccwait), 32'h0);
        chk("reset ccinv", 32'(ccinv), 32'h0);
        chk("reset snoopaddr", ccsnoopaddr0 | ccsnoopaddr1, 32'h0);
        chk("reset dload", dload0 | dload1, 32'h0);
        cctrans = '0;
        dREN    = '0;
        @(posedge CLK);
        #2;
        nRST = 1'b1;

        round(1'b1, 1'b1);

        p_we[0] = 1'b0; p_excl[0] = 1'b0; p_a[0] = 32'h100;
        p_d[0][0] = '0; p_d[0][1] = '0;
        present(0);
        serve(0, 1'b0, '0, '0);

        p_we[1] = 1'b0; p_excl[1] = 1'b1; p_a[1] = 32'h200;
        p_d[1][0] = '0; p_d[1][1] = '0;
        present(1);
        serve(1, 1'b1, 32'h11, 32'h22);

        p_we[0] = 1'b1; p_excl[0] = 1'b0; p_a[0] = 32'h300;
        p_d[0][0] = 32'hDEAD; p_d[0][1] = 32'hBEEF;
        present(0);
        serve(0, 1'b0, '0, '0);

        repeat (2) round(1'b1, 1'b1);

        fixed = 1'b0;
        repeat (40) begin
            mask = $urandom_range(1, 3);
            round(mask[0], mask[1]);
        end

        // Reset in the middle of the second read word.
        fixed = 1'b1;
        p_we[1] = 1'b0; p_excl[1] = 1'b0; p_a[1] = 32'h180;
        p_d[1][0] = '0; p_d[1][1] = '0;
        present(1);
        s.j = 0; s.a = 32'h180; s.inv = 1'b0;
        snp_q.push_back(s);
        r.we = 1'b0; r.a = 32'h180; r.d = '0;
        ram_q.push_back(r);
        e.dw = 2'b01; e.l0 = '0; e.l1 = exp_rd(32'h180);
        ev_q.push_back(e);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (dwait[1] && n < 20);
        chk("mid-reset first word seen", 32'(dwait[1]), 32'h0);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("abort dwait", 32'(dwait), 32'h3);
        chk("abort ramREN", 32'(ramREN), 32'h0);
        chk("abort ramWEN", 32'(ramWEN), 32'h0);
        chk("abort ramaddr", ramaddr, 32'h0);
        chk("abort dload1", dload1, 32'h0);
        chk("abort ccwait", 32'(ccwait), 32'h0);
        chk("abort pending events", 32'(ev_q.size()), 32'h0);
        chk("abort pending ram", 32'(ram_q.size()), 32'h0);
        cctrans = '0; dREN = '0; dWEN = '0; ccwrite = '0;
        repeat (2) @(posedge CLK);
        #2;
        nRST = 1'b1;
        m_last = 1;
        round(1'b1, 1'b1);

        repeat (4) @(posedge CLK);
        chk("leftover events", 32'(ev_q.size()), 32'h0);
        chk("leftover ram accesses", 32'(ram_q.size()), 32'h0);
        chk("leftover snoops", 32'(snp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
